// File: rtl/sata_oob_ctrl.sv
// SATA OOB link-initialization controller: COMRESET/COMWAKE handshakes with the OOB coder,
// per-phase response timeouts with bounded COMRESET retries, and ALIGN lock detection.
module sata_oob_ctrl #(
    parameter int unsigned TIMEOUT       = 1024,
    parameter int unsigned ALIGN_TIMEOUT = 2048,
    parameter int unsigned MAX_RETRY     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       coder_ready,
    output logic       coder_cominit,
    output logic       coder_comwake,
    output logic       oobfinish,
    input  logic       det_cominit,
    input  logic       det_comwake,
    input  logic       rx_align,
    output logic       tx_d102,
    output logic       link_up,
    output logic       fail,
    output logic [3:0] attempts
);

    localparam int unsigned MaxWait = (TIMEOUT > ALIGN_TIMEOUT) ? TIMEOUT : ALIGN_TIMEOUT;
    localparam int unsigned CntW    = (MaxWait > 1) ? $clog2(MaxWait) : 1;

    localparam logic [CntW-1:0] InitLast  = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] AlignLast = CntW'(ALIGN_TIMEOUT - 1);
    localparam logic [3:0]      RetryMax  = 4'(MAX_RETRY);

    typedef enum logic [3:0] {
        StIdle,
        StSendRst,
        StBusyRst,
        StWaitInit,
        StSendWake,
        StBusyWake,
        StWaitWake,
        StWaitAlign,
        StLinkUp,
        StFail
    } state_e;

    state_e          state_q, state_d;
    state_e          retry_state;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      attempts_q, attempts_d;
    logic            busy_seen_q, busy_seen_d;
    logic            cominit_q, cominit_d;
    logic            comwake_q, comwake_d;
    logic            fail_q, fail_d;
    logic            in_wait;

    always_comb begin
        state_d     = state_q;
        attempts_d  = attempts_q;
        busy_seen_d = busy_seen_q;
        cnt_d       = cnt_q;
        cominit_d   = 1'b0;
        comwake_d   = 1'b0;
        retry_state = (attempts_q < RetryMax) ? StSendRst : StFail;
        in_wait     = (state_q == StWaitInit) || (state_q == StWaitWake) ||
                      (state_q == StWaitAlign);

        // Response checks precede timeout checks so a same-cycle response wins.
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StSendRst;
                    attempts_d = '0;
                end
            end
            StSendRst: begin
                if (coder_ready) begin
                    cominit_d  = 1'b1;
                    attempts_d = attempts_q + 4'd1;
                    state_d    = StBusyRst;
                end
            end
            StBusyRst: begin
                if (!coder_ready) begin
                    busy_seen_d = 1'b1;
                end else if (busy_seen_q) begin
                    state_d = StWaitInit;
                end
            end
            StWaitInit: begin
                if (det_cominit) begin
                    state_d = StSendWake;
                end else if (cnt_q == InitLast) begin
                    state_d = retry_state;
                end
            end
            StSendWake: begin
                if (coder_ready) begin
                    comwake_d = 1'b1;
                    state_d   = StBusyWake;
                end
            end
            StBusyWake: begin
                if (!coder_ready) begin
                    busy_seen_d = 1'b1;
                end else if (busy_seen_q) begin
                    state_d = StWaitWake;
                end
            end
            StWaitWake: begin
                if (det_comwake) begin
                    state_d = StWaitAlign;
                end else if (cnt_q == InitLast) begin
                    state_d = retry_state;
                end
            end
            StWaitAlign: begin
                if (rx_align) begin
                    state_d = StLinkUp;
                end else if (cnt_q == AlignLast) begin
                    state_d = retry_state;
                end
            end
            StLinkUp: begin
                if (det_cominit) begin
                    state_d    = StSendRst;
                    attempts_d = '0;
                end
            end
            StFail: begin
                if (start) begin
                    state_d    = StSendRst;
                    attempts_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Every state entry restarts the timer and the coder-busy tracking.
        if (state_d != state_q) begin
            cnt_d       = '0;
            busy_seen_d = 1'b0;
        end else if (in_wait && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        fail_d = (state_d == StFail);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            attempts_q  <= '0;
            busy_seen_q <= 1'b0;
            cominit_q   <= 1'b0;
            comwake_q   <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            attempts_q  <= attempts_d;
            busy_seen_q <= busy_seen_d;
            cominit_q   <= cominit_d;
            comwake_q   <= comwake_d;
            fail_q      <= fail_d;
        end
    end

    assign coder_cominit = cominit_q;
    assign coder_comwake = comwake_q;
    assign fail          = fail_q;
    assign attempts      = attempts_q;
    assign oobfinish     = (state_q == StWaitAlign) || (state_q == StLinkUp);
    assign tx_d102       = (state_q == StWaitAlign);
    assign link_up       = (state_q == StLinkUp);

endmodule
